upsample_stream: RTL and testbench
==================================

# upsample_stream

Streaming 2x image upsampler that replaces the frame-buffered upsample top. It accepts a W x H feature map one pixel per handshake in row-major order. For each source pixel (r,c) it emits one 2x2 output quad: output pixels (2r,2c), (2r,2c+1), (2r+1,2c) and (2r+1,2c+1), plus the output-memory address of the quad's top-left pixel. It supports nearest and bilinear modes, runtime image size up to MAX_W columns, and valid/ready backpressure on both sides. It sits between the generator's conv-output stream and the output feature-map RAM.

## Interface
- DATA_W, 16, signed fixed-point pixel width.
- MAX_W, 128, maximum source width and line-buffer depth. Must be 2..255.
- ADDR_W, 14, output address width.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse. Latches mode/cfg_width/cfg_height. Ignored unless the block is idle.
- mode  in  1  0 = nearest, 1 = bilinear.
- cfg_width  in  8  source width W, 1..MAX_W.
- cfg_height  in  8  source height H, 1..255.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last quad handshake.
- in_data  in  DATA_W  source pixel.
- in_valid  in  1  source pixel valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_tl, out_tr, out_bl, out_br  out  DATA_W each  quad pixels at (2r,2c), (2r,2c+1), (2r+1,2c), (2r+1,2c+1).
- out_addr  out  ADDR_W  address of (2r,2c) = 2r*2W + 2c, truncated to ADDR_W.
- out_valid  in/out  out 1  quad valid.
- out_ready  in  1  sink accepts quad.

## Operation
- States: IDLE, ROW0, BODY, EDGE, FLUSH, FIN.
- Transfers occur when valid && ready.
- Output register is single-entry. A new quad may be loaded when !out_valid || out_ready.
- in_ready = (state is ROW0 or BODY) && output register loadable. It is 0 in IDLE, EDGE, FLUSH and FIN.
- Nearest (mode=0): IDLE -> BODY on start.
  - Each accepted (r,c) loads quad tl=tr=bl=br=p(r,c) at address of (r,c).
  - After W*H inputs -> FIN.
- Bilinear (mode=1): IDLE -> ROW0 on start.
  - ROW0: accepts row 0 into the line buffer with no emission. After W inputs -> BODY if H>1, else FLUSH.
  - BODY, accepting (r+1,c): writes the line buffer at c. For c>=1, emits quad(r,c-1). After c=W-1 -> EDGE.
  - EDGE: one cycle, waiting for a loadable output. Emits quad(r,W-1), then goes to BODY, or to FLUSH if r+1=H-1.
  - FLUSH: emits quad(H-1,c) for c=0..W-1 from the line buffer, one per loadable cycle. Then -> FIN.
  - Quad(r,c) = p(r,c), avg2(p(r,c),p(r,c+1)), avg2(p(r,c),p(r+1,c)), avg4(all four).
  - Clamp: column index c+1 clamps to W-1, row index r+1 clamps to H-1.
- Arithmetic:
  - Inputs are sign-extended by 2 bits.
  - avg2 = (a+b+1)>>>1 and avg4 = (a+b+c+d+2)>>>2, i.e. arithmetic shift with round half toward +inf.
  - Results always fit DATA_W, so no saturation is needed.
- FIN: waits until the output register is empty (last quad taken), pulses done, -> IDLE.
- Quad count: W*H in both modes. Bilinear cycle count is at least W*H + (H-1) + W.
- Asserting rst at any time returns the block to IDLE and drops out_valid. Line-buffer contents need not be cleared.

## Timing
- Reset values: in_ready=0, out_valid=0, busy=0, done=0. out_tl/tr/bl/br=0, out_addr=0.
- Emission latency: out_valid rises on the cycle after the triggering input handshake or EDGE/FLUSH step.
- Holding rule: out_* stay stable while out_valid && !out_ready.
- Throughput: one input per cycle when out_ready is held high. There are no bubbles except EDGE and FLUSH.
- W=1 bilinear: every BODY input is followed by EDGE, and no BODY emission occurs.
- done asserts the cycle after the final out handshake. busy falls on that same cycle.

## Test plan
- Bilinear, W=H=2, inputs 0,4,8,12, out_ready=1 -> quads (0,2,4,6)@0, (4,4,8,8)@2, (8,10,8,10)@8, (12,12,12,12)@10. Then done pulses once.
- Nearest, same inputs -> quads (0,0,0,0)@0, (4,4,4,4)@2, (8,8,8,8)@8, (12,12,12,12)@10. in_ready is never deasserted.
- Rounding, bilinear, W=2, H=1, inputs -1,0 -> quad(0,0) = (-1,0,-1,0). Inputs -3,-2 -> quad(0,0) tr = -2.
- Backpressure: 4x3 bilinear ramp with out_ready toggling 1,0,0,1. Required: 12 quads, bit-exact against a model. No duplicates or drops. out_* held stable while stalled.
- Edge sizes: W=1,H=3 and W=MAX_W,H=1 bilinear -> exactly W*H quads with correct clamped values, and the EDGE/FLUSH cycle counts match the formula.
- Reset mid-BODY (rst low for 1 cycle) -> out_valid=0 and busy=0 immediately. The next start with a 2x2 image produces the first-test result exactly.

Source files
------------

// File: rtl/upsample_stream.sv
// Streaming 2x upsampler: one source pixel in, one 2x2 output quad out, in nearest
// or bilinear mode. Only one source row is buffered, plus two pixel registers.
module upsample_stream #(
    parameter int DATA_W = 16,
    parameter int MAX_W  = 128,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [7:0]        cfg_width,
    input  logic [7:0]        cfg_height,
    output logic              busy,
    output logic              done,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_tl,
    output logic [DATA_W-1:0] out_tr,
    output logic [DATA_W-1:0] out_bl,
    output logic [DATA_W-1:0] out_br,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    input  logic              out_ready
);
    localparam int EW    = DATA_W + 2;
    localparam int LB_AW = $clog2(MAX_W);

    typedef enum logic [2:0] {IDLE, ROW0, BODY, EDGE, FLUSH, FIN} state_t;
    state_t state, state_nx;

    logic              mode_r;
    logic [7:0]        w_r, h_r, col, row, col_inc, col_n;
    logic [DATA_W-1:0] line_buf [MAX_W];
    logic [DATA_W-1:0] top_prev, bot_prev, lb_cur, lb_nxt;
    logic              loadable, in_fire, last_col, last_row, load;
    logic [DATA_W-1:0] q_a, q_b, q_c, q_d;
    logic [7:0]        q_row, q_col;
    logic [15:0]       prod;
    logic [17:0]       addr_full;

    function automatic logic [DATA_W-1:0] avg2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic signed [EW-1:0] s;
        s = $signed({{2{a[DATA_W-1]}}, a}) + $signed({{2{b[DATA_W-1]}}, b}) + EW'(1);
        s = s >>> 1;
        return s[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] avg4(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                               input logic [DATA_W-1:0] c, input logic [DATA_W-1:0] d);
        logic signed [EW-1:0] s;
        s = $signed({{2{a[DATA_W-1]}}, a}) + $signed({{2{b[DATA_W-1]}}, b})
          + $signed({{2{c[DATA_W-1]}}, c}) + $signed({{2{d[DATA_W-1]}}, d}) + EW'(2);
        s = s >>> 2;
        return s[DATA_W-1:0];
    endfunction

    assign loadable = !out_valid || out_ready;
    assign in_ready = ((state == ROW0) || (state == BODY)) && loadable;
    assign in_fire  = in_valid && in_ready;
    assign busy     = (state != IDLE);
    assign last_col = (col == w_r - 8'd1);
    assign last_row = (row == h_r - 8'd1);
    assign col_inc  = last_col ? 8'd0 : col + 8'd1;
    assign col_n    = last_col ? col : col + 8'd1;
    // Before the write at col lands, this still holds the row above.
    assign lb_cur   = line_buf[LB_AW'(col)];
    assign lb_nxt   = line_buf[LB_AW'(col_n)];

    assign prod      = {8'd0, q_row} * {8'd0, w_r};
    assign addr_full = {prod, 2'b00} + {9'd0, q_col, 1'b0};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Nearest quads are built as avg of identical corners, which reduces to the pixel.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        q_a      = in_data;
        q_b      = in_data;
        q_c      = in_data;
        q_d      = in_data;
        q_row    = row;
        q_col    = col;
        case (state)
            IDLE: if (start) state_nx = mode ? ROW0 : BODY;
            ROW0: if (in_fire && last_col) state_nx = (h_r == 8'd1) ? FLUSH : BODY;
            BODY: if (in_fire) begin
                if (!mode_r) begin
                    load = 1'b1;
                    if (last_col && last_row) state_nx = FIN;
                end else begin
                    load  = (col != 8'd0);
                    q_a   = top_prev;
                    q_b   = lb_cur;
                    q_c   = bot_prev;
                    q_row = row - 8'd1;
                    q_col = col - 8'd1;
                    if (last_col) state_nx = EDGE;
                end
            end
            EDGE: if (loadable) begin
                load     = 1'b1;
                q_a      = top_prev;
                q_b      = top_prev;
                q_c      = bot_prev;
                q_d      = bot_prev;
                q_row    = row - 8'd1;
                q_col    = w_r - 8'd1;
                state_nx = last_row ? FLUSH : BODY;
            end
            FLUSH: if (loadable) begin
                load  = 1'b1;
                q_a   = lb_cur;
                q_b   = lb_nxt;
                q_c   = lb_cur;
                q_d   = lb_nxt;
                q_row = h_r - 8'd1;
                if (last_col) state_nx = FIN;
            end
            FIN: if (loadable) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_r    <= 1'b0;
            w_r       <= 8'd0;
            h_r       <= 8'd0;
            col       <= 8'd0;
            row       <= 8'd0;
            top_prev  <= '0;
            bot_prev  <= '0;
            done      <= 1'b0;
            out_tl    <= '0;
            out_tr    <= '0;
            out_bl    <= '0;
            out_br    <= '0;
            out_addr  <= '0;
            out_valid <= 1'b0;
        end else begin
            done <= (state == FIN) && loadable;
            case (state)
                IDLE: if (start) begin
                    mode_r <= mode;
                    w_r    <= cfg_width;
                    h_r    <= cfg_height;
                    col    <= 8'd0;
                    row    <= 8'd0;
                end
                ROW0: if (in_fire) begin
                    col <= col_inc;
                    if (last_col) row <= 8'd1;
                end
                BODY: if (in_fire) begin
                    col      <= col_inc;
                    top_prev <= lb_cur;
                    bot_prev <= in_data;
                    if (!mode_r && last_col) row <= row + 8'd1;
                end
                EDGE:  if (loadable && !last_row) row <= row + 8'd1;
                FLUSH: if (loadable) col <= col_inc;
                default: ;
            endcase
            if (load) begin
                out_tl    <= q_a;
                out_tr    <= avg2(q_a, q_b);
                out_bl    <= avg2(q_a, q_c);
                out_br    <= avg4(q_a, q_b, q_c, q_d);
                out_addr  <= ADDR_W'(addr_full);
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) line_buf[LB_AW'(col)] <= in_data;
    end
endmodule

// File: tb/tb_upsample_stream.sv
// Directed bench for upsample_stream: hand-computed quads plus a frame-based
// reference for the larger ramp images.
module tb_upsample_stream;
    logic        clk = 1'b0;
    logic        rst, start, mode, in_valid, out_ready;
    logic [7:0]  cfg_width, cfg_height;
    logic [15:0] in_data;
    logic        busy, done, in_ready, out_valid;
    logic [15:0] out_tl, out_tr, out_bl, out_br;
    logic [13:0] out_addr;

    typedef struct packed {
        logic [15:0] tl, tr, bl, br;
        logic [13:0] addr;
    } quad_t;

    logic signed [15:0] img [0:1023];
    quad_t got[$];
    int    checks = 0, failures = 0;
    int    busy_cycles, done_pulses, stall_changes, ready_drops;
    bit    timed_out;

    upsample_stream #(.DATA_W(16), .MAX_W(128), .ADDR_W(14)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .busy(busy), .done(done),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_tl(out_tl), .out_tr(out_tr), .out_bl(out_bl), .out_br(out_br),
        .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Frame-based reference with explicit edge clamping.
    function automatic quad_t ref_quad(input int k, input int w, input int h);
        quad_t q;
        int r, c, cn, rn, a, b, cc, d, t;
        r  = k / w;
        c  = k % w;
        cn = (c + 1 < w) ? c + 1 : c;
        rn = (r + 1 < h) ? r + 1 : r;
        a  = img[r*w + c];
        b  = img[r*w + cn];
        cc = img[rn*w + c];
        d  = img[rn*w + cn];
        t = a;                         q.tl = t[15:0];
        t = (a + b + 1) >>> 1;         q.tr = t[15:0];
        t = (a + cc + 1) >>> 1;        q.bl = t[15:0];
        t = (a + b + cc + d + 2) >>> 2; q.br = t[15:0];
        t = 4*r*w + 2*c;               q.addr = t[13:0];
        return q;
    endfunction

    // Drives one image and records every quad handshake; rpat[cyc%4] is out_ready.
    task automatic stream(input bit m, input int w, input int h, input logic [3:0] rpat, input int budget);
        int    n, idx, cyc, tail;
        bit    stalled, seen_done;
        quad_t cur, held;
        n = w * h; idx = 0; cyc = 0; tail = 0; stalled = 0; seen_done = 0; held = '0;
        got.delete();
        busy_cycles = 0; done_pulses = 0; stall_changes = 0; ready_drops = 0;
        @(negedge clk);
        start = 1'b1; mode = m; cfg_width = 8'(w); cfg_height = 8'(h);
        @(negedge clk);
        start = 1'b0;
        while (tail < 3 && cyc < budget) begin
            out_ready = rpat[cyc % 4];
            in_valid  = (idx < n);
            in_data   = (idx < n) ? img[idx] : 16'd0;
            #1;
            cur = {out_tl, out_tr, out_bl, out_br, out_addr};
            if (stalled && (!out_valid || cur !== held)) stall_changes++;
            if (busy) busy_cycles++;
            if (done) begin done_pulses++; seen_done = 1; end
            if (seen_done) tail++;
            if (in_valid && !in_ready) ready_drops++;
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) got.push_back(cur);
            stalled = out_valid && !out_ready;
            held    = cur;
            cyc++;
            @(negedge clk);
        end
        timed_out = !seen_done;
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; cfg_width = '0; cfg_height = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++;
        if ({out_tl, out_tr, out_bl, out_br, out_addr} !== 78'd0) begin
            failures++; $display("FAIL reset_outputs: got %h expected 0", {out_tl, out_tr, out_bl, out_br, out_addr});
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_bilinear_2x2();
        quad_t exp_q[4];
        img[0] = 16'sd0; img[1] = 16'sd4; img[2] = 16'sd8; img[3] = 16'sd12;
        exp_q[0] = {16'd0,  16'd2,  16'd4,  16'd6,  14'd0};
        exp_q[1] = {16'd4,  16'd4,  16'd8,  16'd8,  14'd2};
        exp_q[2] = {16'd8,  16'd10, 16'd8,  16'd10, 14'd8};
        exp_q[3] = {16'd12, 16'd12, 16'd12, 16'd12, 14'd10};
        stream(1'b1, 2, 2, 4'b1111, 100);
        checks++; if (timed_out) begin failures++; $display("FAIL bil2x2_timeout: done not seen within budget"); end
        checks++; if (got.size() != 4) begin failures++; $display("FAIL bil2x2_count: got %0d expected 4", got.size()); end
        for (int i = 0; i < got.size() && i < 4; i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin failures++; $display("FAIL bil2x2_quad%0d: got %h expected %h", i, got[i], exp_q[i]); end
        end
        checks++; if (done_pulses != 1) begin failures++; $display("FAIL bil2x2_done: got %0d pulses expected 1", done_pulses); end
        checks++; if (busy_cycles != 8) begin failures++; $display("FAIL bil2x2_cycles: got %0d expected 8", busy_cycles); end
    endtask

    task automatic test_nearest_2x2();
        quad_t exp_q[4];
        img[0] = 16'sd0; img[1] = 16'sd4; img[2] = 16'sd8; img[3] = 16'sd12;
        exp_q[0] = {16'd0,  16'd0,  16'd0,  16'd0,  14'd0};
        exp_q[1] = {16'd4,  16'd4,  16'd4,  16'd4,  14'd2};
        exp_q[2] = {16'd8,  16'd8,  16'd8,  16'd8,  14'd8};
        exp_q[3] = {16'd12, 16'd12, 16'd12, 16'd12, 14'd10};
        stream(1'b0, 2, 2, 4'b1111, 100);
        checks++; if (timed_out) begin failures++; $display("FAIL near2x2_timeout: done not seen within budget"); end
        checks++; if (got.size() != 4) begin failures++; $display("FAIL near2x2_count: got %0d expected 4", got.size()); end
        for (int i = 0; i < got.size() && i < 4; i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin failures++; $display("FAIL near2x2_quad%0d: got %h expected %h", i, got[i], exp_q[i]); end
        end
        checks++; if (ready_drops != 0) begin failures++; $display("FAIL near2x2_in_ready: dropped %0d times expected 0", ready_drops); end
        checks++; if (done_pulses != 1) begin failures++; $display("FAIL near2x2_done: got %0d pulses expected 1", done_pulses); end
    endtask

    task automatic test_rounding();
        quad_t exp_q[2];
        img[0] = -16'sd1; img[1] = 16'sd0;
        exp_q[0] = {16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 14'd0};
        exp_q[1] = {16'h0000, 16'h0000, 16'h0000, 16'h0000, 14'd2};
        stream(1'b1, 2, 1, 4'b1111, 100);
        checks++; if (got.size() != 2) begin failures++; $display("FAIL round_a_count: got %0d expected 2", got.size()); end
        for (int i = 0; i < got.size() && i < 2; i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin failures++; $display("FAIL round_a_quad%0d: got %h expected %h", i, got[i], exp_q[i]); end
        end
        checks++; if (busy_cycles != 5) begin failures++; $display("FAIL round_a_cycles: got %0d expected 5", busy_cycles); end
        img[0] = -16'sd3; img[1] = -16'sd2;
        exp_q[0] = {16'hFFFD, 16'hFFFE, 16'hFFFD, 16'hFFFE, 14'd0};
        exp_q[1] = {16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE, 14'd2};
        stream(1'b1, 2, 1, 4'b1111, 100);
        checks++; if (got.size() != 2) begin failures++; $display("FAIL round_b_count: got %0d expected 2", got.size()); end
        for (int i = 0; i < got.size() && i < 2; i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin failures++; $display("FAIL round_b_quad%0d: got %h expected %h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        quad_t e;
        for (int i = 0; i < 12; i++) img[i] = 16'(i*100 - 500);
        stream(1'b1, 4, 3, 4'b1001, 500);
        checks++; if (timed_out) begin failures++; $display("FAIL bp_timeout: done not seen within budget"); end
        checks++; if (got.size() != 12) begin failures++; $display("FAIL bp_count: got %0d expected 12", got.size()); end
        for (int i = 0; i < got.size() && i < 12; i++) begin
            e = ref_quad(i, 4, 3);
            checks++;
            if (got[i] !== e) begin failures++; $display("FAIL bp_quad%0d: got %h expected %h", i, got[i], e); end
        end
        checks++; if (stall_changes != 0) begin failures++; $display("FAIL bp_hold: got %0d changes while stalled expected 0", stall_changes); end
        checks++; if (done_pulses != 1) begin failures++; $display("FAIL bp_done: got %0d pulses expected 1", done_pulses); end
    endtask

    task automatic test_edge_sizes();
        quad_t e;
        img[0] = 16'sd5; img[1] = -16'sd7; img[2] = 16'sd20;
        stream(1'b1, 1, 3, 4'b1111, 200);
        checks++; if (got.size() != 3) begin failures++; $display("FAIL w1_count: got %0d expected 3", got.size()); end
        for (int i = 0; i < got.size() && i < 3; i++) begin
            e = ref_quad(i, 1, 3);
            checks++;
            if (got[i] !== e) begin failures++; $display("FAIL w1_quad%0d: got %h expected %h", i, got[i], e); end
        end
        checks++; if (busy_cycles != 7) begin failures++; $display("FAIL w1_cycles: got %0d expected 7", busy_cycles); end

        for (int i = 0; i < 128; i++) img[i] = 16'((i*37) % 200 - 100);
        stream(1'b1, 128, 1, 4'b1111, 1000);
        checks++; if (got.size() != 128) begin failures++; $display("FAIL wmax_count: got %0d expected 128", got.size()); end
        for (int i = 0; i < got.size() && i < 128; i++) begin
            e = ref_quad(i, 128, 1);
            checks++;
            if (got[i] !== e) begin failures++; $display("FAIL wmax_quad%0d: got %h expected %h", i, got[i], e); end
        end
        checks++; if (busy_cycles != 257) begin failures++; $display("FAIL wmax_cycles: got %0d expected 257", busy_cycles); end
    endtask

    task automatic test_reset_mid_body();
        quad_t exp_q[4];
        int    idx, cyc;
        for (int i = 0; i < 12; i++) img[i] = 16'(i*3);
        @(negedge clk);
        start = 1'b1; mode = 1'b1; cfg_width = 8'd4; cfg_height = 8'd3;
        @(negedge clk);
        start = 1'b0; out_ready = 1'b0; in_valid = 1'b1; idx = 0; cyc = 0;
        while (cyc < 30 && !out_valid) begin
            in_data = img[idx];
            #1;
            if (in_ready) idx++;
            cyc++;
            @(negedge clk);
        end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rstmid_pre_valid: got %b expected 1", out_valid); end
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        img[0] = 16'sd0; img[1] = 16'sd4; img[2] = 16'sd8; img[3] = 16'sd12;
        exp_q[0] = {16'd0,  16'd2,  16'd4,  16'd6,  14'd0};
        exp_q[1] = {16'd4,  16'd4,  16'd8,  16'd8,  14'd2};
        exp_q[2] = {16'd8,  16'd10, 16'd8,  16'd10, 14'd8};
        exp_q[3] = {16'd12, 16'd12, 16'd12, 16'd12, 14'd10};
        stream(1'b1, 2, 2, 4'b1111, 100);
        checks++; if (got.size() != 4) begin failures++; $display("FAIL rstmid_count: got %0d expected 4", got.size()); end
        for (int i = 0; i < got.size() && i < 4; i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin failures++; $display("FAIL rstmid_quad%0d: got %h expected %h", i, got[i], exp_q[i]); end
        end
        checks++; if (done_pulses != 1) begin failures++; $display("FAIL rstmid_done: got %0d pulses expected 1", done_pulses); end
    endtask

    initial begin
        test_reset();
        test_bilinear_2x2();
        test_nearest_2x2();
        test_rounding();
        test_backpressure();
        test_edge_sizes();
        test_reset_mid_body();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
